// File: rtl/pixel_fill_arbiter_if.sv
// pixel_fill_arbiter_if: CPU pixel, fill-command and pixel-RAM port 0 signals.
// cpu_wait exists only when PIXEL_FILL_STARVE_GUARD_EN is defined.
interface pixel_fill_arbiter_if #(parameter int ADDR_W = 19);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_din;
    logic              cpu_dout;
`ifdef PIXEL_FILL_STARVE_GUARD_EN
    logic              cpu_wait;
`endif
    logic              fill_start;
    logic [9:0]        fill_x0;
    logic [8:0]        fill_y0;
    logic [9:0]        fill_w;
    logic [8:0]        fill_h;
    logic              fill_color;
    logic              fill_busy;
    logic              fill_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_din;
    logic              ram_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
        input  ram_dout,
`ifdef PIXEL_FILL_STARVE_GUARD_EN
        output cpu_wait,
`endif
        output cpu_dout, fill_busy, fill_done, ram_addr, ram_we, ram_din
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
        output ram_dout,
`ifdef PIXEL_FILL_STARVE_GUARD_EN
        input  cpu_wait,
`endif
        input  cpu_dout, fill_busy, fill_done, ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/pixel_fill_arbiter.sv
// pixel_fill_arbiter: shares pixel-RAM port 0 between the CPU and a rectangle-fill engine.
// Define PIXEL_FILL_STARVE_GUARD_EN to force an engine grant after STARVE_LIMIT denied cycles.
module pixel_fill_arbiter #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int ADDR_W       = 19,
    parameter int STARVE_LIMIT = 16
) (
    input logic clock,
    input logic reset,
    pixel_fill_arbiter_if.slave bus
);
    localparam logic [10:0] W11 = 11'(SCREEN_W);
    localparam logic [9:0]  H10 = 10'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

    state_e            state_q, state_d;
    logic [9:0]        x_q, x_d, x0_q, x0_d;
    logic [8:0]        y_q, y_d;
    logic [10:0]       xe_q, xe_d;
    logic [9:0]        ye_q, ye_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              color_q, color_d;
    logic [10:0]       sum_x;
    logic [9:0]        sum_y;
    logic              empty, grant, force_g, last_col, last_row;

    assign sum_x    = {1'b0, bus.fill_x0} + {1'b0, bus.fill_w};
    assign sum_y    = {1'b0, bus.fill_y0} + {1'b0, bus.fill_h};
    assign empty    = bus.fill_w == '0 || bus.fill_h == '0 ||
                      {1'b0, bus.fill_x0} >= W11 || {1'b0, bus.fill_y0} >= H10;
    assign last_col = ({1'b0, x_q} + 11'd1) == xe_q;
    assign last_row = ({1'b0, y_q} + 10'd1) == ye_q;
    assign grant    = state_q == FILL && (!bus.cpu_req || force_g);

`ifdef PIXEL_FILL_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    assign force_g      = state_q == FILL && starve_q == SW'(STARVE_LIMIT);
    assign bus.cpu_wait = force_g;
    assign starve_d     = (state_q == FILL && !grant) ? starve_q + SW'(1) : '0;
    always_ff @(posedge clock)
        starve_q <= reset ? '0 : starve_d;
`else
    assign force_g = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        x0_d    = x0_q;
        y_d     = y_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        row_d   = row_q;
        color_d = color_q;
        case (state_q)
            IDLE: if (bus.fill_start) begin
                x_d     = bus.fill_x0;
                x0_d    = bus.fill_x0;
                y_d     = bus.fill_y0;
                color_d = bus.fill_color;
                xe_d    = sum_x > W11 ? W11 : sum_x;
                ye_d    = sum_y > H10 ? H10 : sum_y;
                row_d   = ADDR_W'(bus.fill_y0) * ADDR_W'(SCREEN_W);
                state_d = empty ? DONE : FILL;
            end
            FILL: if (grant) begin
                x_d = last_col ? x0_q : x_q + 10'd1;
                if (last_col) begin
                    y_d     = y_q + 9'd1;
                    row_d   = row_q + ADDR_W'(SCREEN_W);
                    state_d = last_row ? DONE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            x0_q    <= '0;
            y_q     <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            row_q   <= '0;
            color_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            x0_q    <= x0_d;
            y_q     <= y_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            row_q   <= row_d;
            color_q <= color_d;
        end
    end

    assign bus.fill_busy = state_q == FILL;
    assign bus.fill_done = state_q == DONE;
    assign bus.cpu_dout  = bus.ram_dout;
    assign bus.ram_addr  = grant ? row_q + ADDR_W'(x_q) : bus.cpu_addr;
    assign bus.ram_din   = grant ? color_q : bus.cpu_din;
    // Reset must block CPU writes too, not just engine writes.
    assign bus.ram_we    = !reset && (grant || (bus.cpu_req && bus.cpu_we));
endmodule

// File: tb/tb_pixel_fill_arbiter.sv
// tb_pixel_fill_arbiter: randomized and directed fills checked against a pixel-list model.
module tb_pixel_fill_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int errs = 0;

    pixel_fill_arbiter_if #(.ADDR_W(19)) bus();
    pixel_fill_arbiter #(.SCREEN_W(640), .SCREEN_H(480), .ADDR_W(19), .STARVE_LIMIT(16)) dut (
        .clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rand_cpu(input logic req);
        bus.cpu_req  = req;
        bus.cpu_we   = 1'($urandom);
        bus.cpu_addr = 19'($urandom_range(0, 307199));
        bus.cpu_din  = 1'($urandom);
        bus.ram_dout = 1'($urandom);
    endtask

    task automatic rand_start();
        bus.fill_start = 1'($urandom);
        bus.fill_x0    = 10'($urandom);
        bus.fill_y0    = 9'($urandom);
        bus.fill_w     = 10'($urandom);
        bus.fill_h     = 9'($urandom);
        bus.fill_color = 1'($urandom);
    endtask

    task automatic check_cpu_path(input string tag);
        chk({tag, "_we"}, 32'(bus.ram_we), 32'(bus.cpu_we));
        chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(bus.cpu_addr));
        chk({tag, "_din"}, 32'(bus.ram_din), 32'(bus.cpu_din));
    endtask

    // mode: 0 random CPU, 1 CPU every other cycle, 2 no CPU, 3 CPU always
    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input logic c, input int mode);
        int xe, ye, cyc, deny;
        int q[$];
        logic forced;
        xe = (x0 + w > 640) ? 640 : x0 + w;
        ye = (y0 + h > 480) ? 480 : y0 + h;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                q.push_back(y * 640 + x);
        @(negedge clock);
        rand_cpu(1'b0);
        bus.fill_start = 1'b1;
        bus.fill_x0    = 10'(x0);
        bus.fill_y0    = 9'(y0);
        bus.fill_w     = 10'(w);
        bus.fill_h     = 9'(h);
        bus.fill_color = c;
        #1;
        chk("idle_busy", 32'(bus.fill_busy), 0);
        chk("idle_we", 32'(bus.ram_we), 0);
        cyc = 0;
        deny = 0;
        @(negedge clock);
        while (q.size() > 0 && cyc < 4000) begin
            case (mode)
                1: begin
                    rand_cpu(cyc % 2 == 0);
                    bus.cpu_we   = 1'b1;
                    bus.cpu_addr = 19'd5;
                    bus.cpu_din  = 1'b1;
                end
                2: rand_cpu(1'b0);
                3: rand_cpu(1'b1);
                default: rand_cpu(1'($urandom));
            endcase
            rand_start();
            #1;
            forced = 1'b0;
`ifdef PIXEL_FILL_STARVE_GUARD_EN
            forced = bus.cpu_req && deny == 16;
            chk("cpu_wait", 32'(bus.cpu_wait), 32'(forced));
`endif
            chk("fill_busy", 32'(bus.fill_busy), 1);
            chk("fill_done_early", 32'(bus.fill_done), 0);
            chk("cpu_dout", 32'(bus.cpu_dout), 32'(bus.ram_dout));
            if (bus.cpu_req && !forced) begin
                check_cpu_path("cpu");
                deny++;
            end else begin
                chk("fill_we", 32'(bus.ram_we), 1);
                chk("fill_addr", 32'(bus.ram_addr), 32'(q[0]));
                chk("fill_din", 32'(bus.ram_din), 32'(c));
                void'(q.pop_front());
                deny = 0;
            end
            cyc++;
            @(negedge clock);
        end
        if (q.size() > 0)
            chk("fill_timeout_left", q.size(), 0);
        rand_cpu(1'b0);
        rand_start();
        #1;
        chk("done_pulse", 32'(bus.fill_done), 1);
        chk("done_busy", 32'(bus.fill_busy), 0);
        chk("done_we", 32'(bus.ram_we), 0);
        @(negedge clock);
        rand_cpu(1'b0);
        bus.fill_start = 1'b0;
        #1;
        chk("after_done", 32'(bus.fill_done), 0);
        chk("after_busy", 32'(bus.fill_busy), 0);
        chk("after_we", 32'(bus.ram_we), 0);
    endtask

    initial begin
        rand_cpu(1'b1);
        bus.cpu_we = 1'b1;
        bus.fill_start = 1'b0;
        bus.fill_x0 = '0;
        bus.fill_y0 = '0;
        bus.fill_w = '0;
        bus.fill_h = '0;
        bus.fill_color = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_busy", 32'(bus.fill_busy), 0);
        chk("rst_done", 32'(bus.fill_done), 0);
        chk("rst_we", 32'(bus.ram_we), 0);
        reset = 1'b0;

        run_fill(638, 479, 5, 4, 1'b1, 2);
        run_fill(20, 20, 0, 7, 1'b1, 0);
        run_fill(700, 20, 5, 7, 1'b1, 0);
        run_fill(10, 2, 3, 2, 1'b1, 1);
        run_fill(600, 460, 100, 100, 1'b0, 0);

        @(negedge clock);
        rand_cpu(1'b0);
        bus.fill_start = 1'b1;
        bus.fill_x0 = 10'd100;
        bus.fill_y0 = 9'd50;
        bus.fill_w = 10'd10;
        bus.fill_h = 9'd10;
        bus.fill_color = 1'b1;
        @(negedge clock);
        bus.fill_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_cpu(1'b0);
            #1;
            chk("pre_rst_we", 32'(bus.ram_we), 1);
            chk("pre_rst_addr", 32'(bus.ram_addr), 50 * 640 + 100 + i);
            @(negedge clock);
        end
        reset = 1'b1;
        rand_cpu(1'b1);
        bus.cpu_we = 1'b1;
        #1;
        chk("mid_rst_we", 32'(bus.ram_we), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_cpu(1'b0);
            #1;
            chk("post_rst_busy", 32'(bus.fill_busy), 0);
            chk("post_rst_done", 32'(bus.fill_done), 0);
            chk("post_rst_we", 32'(bus.ram_we), 0);
            @(negedge clock);
        end

        for (int i = 0; i < 12; i++)
            run_fill($urandom_range(0, 650), $urandom_range(0, 490),
                     $urandom_range(0, 30), $urandom_range(0, 20), 1'($urandom), 0);

`ifdef PIXEL_FILL_STARVE_GUARD_EN
        run_fill(5, 5, 8, 4, 1'b1, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
